uart_tx_arbiter: RTL and testbench

Round-robin scheduler that shares one UART transmitter (16x oversampled, 1 bit = 16 clk) among NUM_REQ requesters. Selects a requester, latches its byte, launches the transmitter with a one-cycle start pulse, then waits for frame completion. A watchdog recovers if the transmitter never reports done. Sits between client logic and the UART TX datapath, in the same clock domain as the RX top.

---
 rtl/uart_pkg.sv | 15 +
 rtl/rr_pick.sv | 27 ++
 rtl/uart_tx_arbiter.sv | 112 +++++++++++
 tb/tb_uart_tx_arbiter.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART TX arbitration path: FSM states and frame timing.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT_DONE
  } arb_state_e;

  localparam int OVERSAMPLE         = 16;
  localparam int FRAME_BITS         = 11;
  localparam int FRAME_CYCLES       = OVERSAMPLE * FRAME_BITS;
  localparam int DEF_TIMEOUT_CYCLES = 256;

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority picker: first asserted request at or after ptr, wrapping modulo NUM_REQ.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDW     = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDW-1:0]     ptr,
  output logic               valid,
  output logic [IDW-1:0]     winner
);

  always_comb begin
    logic [IDW-1:0] idx;
    valid  = 1'b0;
    winner = '0;
    idx    = '0;
    // Scan farthest-first so the closest hit to ptr is the last one written.
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = IDW'((int'(ptr) + k) % NUM_REQ);
      if (req[idx]) begin
        valid  = 1'b1;
        winner = idx;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin owner of a shared UART transmitter: pick, latch, launch, wait for done or watchdog.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            ack,
  output logic [NUM_REQ-1:0]            done,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          tx_start,
  output logic [DATA_WIDTH-1:0]         tx_data,
  input  logic                          tx_busy,
  input  logic                          tx_done,
  output logic                          timeout_err
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int WDW = $clog2(TIMEOUT_CYCLES);
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT_CYCLES - 1);

  if (TIMEOUT_CYCLES <= FRAME_CYCLES) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must exceed one UART frame");
  end

  arb_state_e            state, state_d;
  logic [IDW-1:0]        ptr, ptr_d, grant_d, win, nxt;
  logic [WDW-1:0]        wd, wd_d;
  logic [NUM_REQ-1:0]    ack_d, done_d;
  logic [DATA_WIDTH-1:0] data_d;
  logic                  start_d, terr_d, pick_valid;

  rr_pick #(.NUM_REQ(NUM_REQ), .IDW(IDW)) u_pick (
    .req    (req),
    .ptr    (ptr),
    .valid  (pick_valid),
    .winner (win)
  );

  assign nxt = (grant_id == IDW'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;

  always_comb begin
    state_d = state;
    ptr_d   = ptr;
    wd_d    = wd;
    grant_d = grant_id;
    data_d  = tx_data;
    terr_d  = timeout_err;
    ack_d   = '0;
    done_d  = '0;
    start_d = 1'b0;
    case (state)
      IDLE: begin
        if (pick_valid && !tx_busy) begin
          grant_d    = win;
          data_d     = req_data[int'(win)*DATA_WIDTH +: DATA_WIDTH];
          ack_d[win] = 1'b1;
          start_d    = 1'b1;
          state_d    = LAUNCH;
        end
      end
      LAUNCH: begin
        wd_d    = '0;
        state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        wd_d = wd + 1'b1;
        // A done arriving on the last watchdog cycle still counts as a clean finish.
        if (tx_done) begin
          done_d[grant_id] = 1'b1;
          ptr_d            = nxt;
          state_d          = IDLE;
        end else if (wd == WD_LAST) begin
          terr_d  = 1'b1;
          ptr_d   = nxt;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      ptr         <= '0;
      wd          <= '0;
      grant_id    <= '0;
      tx_data     <= '0;
      timeout_err <= 1'b0;
      ack         <= '0;
      done        <= '0;
      tx_start    <= 1'b0;
    end else begin
      state       <= state_d;
      ptr         <= ptr_d;
      wd          <= wd_d;
      grant_id    <= grant_d;
      tx_data     <= data_d;
      timeout_err <= terr_d;
      ack         <= ack_d;
      done        <= done_d;
      tx_start    <= start_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed vectors, hand sequences and randomized traffic vs a reference model.
module tb_uart_tx_arbiter;

  localparam int N     = 4;
  localparam int DW    = 8;
  localparam int TO    = 256;
  localparam int FRAME = 176;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]  ack, done;
  logic [1:0]    grant_id;
  logic          tx_start;
  logic [DW-1:0] tx_data;
  logic          tx_busy, tx_done, timeout_err;

  int checks = 0;
  int failures = 0;

  uart_tx_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .ack(ack), .done(done),
    .grant_id(grant_id), .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy),
    .tx_done(tx_done), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // Reference model: who owns the transmitter, how long it has waited, expected outputs.
  int          m_ptr = 0, m_owner = -1, m_wait = 0;
  bit          m_launch = 0;
  logic [N-1:0] e_ack = '0, e_done = '0;
  logic        e_start = 0, e_terr = 0;
  int          e_gid = 0;
  logic [DW-1:0] e_data = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic int pick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++)
      if (r[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  task automatic model_step();
    int w;
    e_ack = '0; e_done = '0; e_start = 0;
    if (rst) begin
      m_ptr = 0; m_owner = -1; m_launch = 0; m_wait = 0;
      e_gid = 0; e_data = '0; e_terr = 0;
    end else if (m_launch) begin
      m_launch = 0; m_wait = 0;
    end else if (m_owner < 0) begin
      w = pick(req, m_ptr);
      if (w >= 0 && !tx_busy) begin
        m_owner = w; m_launch = 1; e_start = 1; e_ack[w] = 1'b1;
        e_gid = w; e_data = req_data[w*DW +: DW];
      end
    end else if (tx_done) begin
      e_done[m_owner] = 1'b1; m_ptr = (m_owner + 1) % N; m_owner = -1;
    end else if (m_wait == TO - 1) begin
      e_terr = 1; m_ptr = (m_owner + 1) % N; m_owner = -1;
    end else begin
      m_wait++;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    chk("m_ack", ack, e_ack);
    chk("m_done", done, e_done);
    chk("m_tx_start", tx_start, e_start);
    chk("m_grant_id", grant_id, 64'(e_gid));
    chk("m_tx_data", tx_data, e_data);
    chk("m_timeout_err", timeout_err, e_terr);
  endtask

  // Caller has just seen the launch; DUT is in its one launch cycle.
  task automatic finish_frame(input int w, input int dly, input string tag);
    tx_busy = 1; tick();
    repeat (dly) tick();
    tx_done = 1; tx_busy = 0; tick(); tx_done = 0;
    chk({tag, "_done"}, done, 64'(1 << w));
  endtask

  task automatic chk_launch(input string tag, input int w, input logic [7:0] b);
    chk({tag, "_start"}, tx_start, 1);
    chk({tag, "_ack"}, ack, 64'(1 << w));
    chk({tag, "_gid"}, grant_id, 64'(w));
    chk({tag, "_data"}, tx_data, b);
  endtask

  typedef struct {
    logic [N-1:0] r;
    logic [31:0]  d;
    int           w;
    logic [7:0]   b;
  } vec_t;
  vec_t tbl[10];

  int   tx_left;
  bit   tx_never;

  initial begin
    tbl[0] = '{4'b0001, 32'hFFEEDD3C, 0, 8'h3C};
    tbl[1] = '{4'b1111, 32'h44332211, 1, 8'h22};
    tbl[2] = '{4'b0001, 32'h000000FF, 0, 8'hFF};
    tbl[3] = '{4'b1010, 32'h7700AA00, 1, 8'hAA};
    tbl[4] = '{4'b1010, 32'h7700AA00, 3, 8'h77};
    tbl[5] = '{4'b1100, 32'h5A690000, 2, 8'h69};
    tbl[6] = '{4'b0110, 32'h00C3B200, 1, 8'hB2};
    tbl[7] = '{4'b1000, 32'h01000000, 3, 8'h01};
    tbl[8] = '{4'b0101, 32'h00F0000F, 0, 8'h0F};
    tbl[9] = '{4'b0101, 32'h00F0000F, 2, 8'hF0};

    rst = 1; req = '0; req_data = '0; tx_busy = 0; tx_done = 0;
    tick(); tick();
    chk("rst_ack", ack, 0); chk("rst_done", done, 0); chk("rst_start", tx_start, 0);
    chk("rst_gid", grant_id, 0); chk("rst_data", tx_data, 0); chk("rst_terr", timeout_err, 0);
    rst = 0;

    // Single requester, full-length frame.
    req = 4'b0001; req_data = 32'h000000A5; tick();
    chk_launch("t1", 0, 8'hA5);
    req = '0;
    finish_frame(0, FRAME - 2, "t1");

    // All four at once, each dropped on its own ack.
    rst = 1; tick(); rst = 0;
    req = 4'b1111; req_data = 32'h44332211;
    for (int k = 0; k < N; k++) begin
      logic [31:0] dv;
      dv = req_data;
      tick();
      chk_launch("t2", k, dv[k*8 +: 8]);
      req[k] = 1'b0;
      finish_frame(k, 3, "t2");
    end

    // Pointer sweep from a known pointer of 0.
    for (int i = 0; i < 10; i++) begin
      req = tbl[i].r; req_data = tbl[i].d; tick();
      chk_launch("tbl", tbl[i].w, tbl[i].b);
      req = '0;
      finish_frame(tbl[i].w, 2 + i, "tbl");
    end

    // req0 held continuously, req2 once: order 0,2,0.
    req = 4'b0101; req_data = 32'h00300010; tick();
    chk_launch("t3a", 0, 8'h10);
    finish_frame(0, 4, "t3a");
    tick();
    chk_launch("t3b", 2, 8'h30);
    req[2] = 1'b0;
    finish_frame(2, 4, "t3b");
    tick();
    chk_launch("t3c", 0, 8'h10);
    req = '0;
    finish_frame(0, 4, "t3c");

    // Transmitter busy holds off the launch.
    req = 4'b0010; req_data = 32'h0000C800; tx_busy = 1;
    repeat (40) begin tick(); chk("t4_hold", tx_start, 0); end
    tx_busy = 0; tick();
    chk_launch("t4", 1, 8'hC8);
    req = '0;
    finish_frame(1, 3, "t4");

    // Watchdog expiry, then the pending request is served.
    req = 4'b0001; req_data = 32'h0000005E; tick();
    chk_launch("t5", 0, 8'h5E);
    req = '0; tx_busy = 1; tick();
    repeat (TO - 1) tick();
    chk("t5_terr_early", timeout_err, 0);
    req = 4'b0100; req_data = 32'h00D10000; tx_busy = 0; tick();
    chk("t5_terr", timeout_err, 1); chk("t5_nodone", done, 0);
    tick();
    chk_launch("t5b", 2, 8'hD1);
    req = '0;
    finish_frame(2, 5, "t5b");
    chk("t5_sticky", timeout_err, 1);

    // Reset mid-frame, then a stale tx_done.
    req = 4'b1000; req_data = 32'h99000000; tick();
    chk_launch("t6", 3, 8'h99);
    req = '0; tx_busy = 1;
    repeat (10) tick();
    rst = 1; tick(); rst = 0;
    chk("t6_ack", ack, 0); chk("t6_done", done, 0); chk("t6_start", tx_start, 0);
    chk("t6_gid", grant_id, 0); chk("t6_data", tx_data, 0); chk("t6_terr", timeout_err, 0);
    repeat (5) tick();
    tx_done = 1; tx_busy = 0; tick(); tx_done = 0;
    chk("t6_stale", done, 0);
    req = 4'b0011; req_data = 32'h00004D4C; tick();
    chk_launch("t6b", 0, 8'h4C);
    req = '0;
    finish_frame(0, 2, "t6b");

    // Randomized traffic against the model.
    tx_left = 0; tx_never = 0;
    for (int cyc = 0; cyc < 6000; cyc++) begin
      rst = ($urandom_range(0, 1999) == 0);
      tx_done = 0;
      if (tx_start) begin
        tx_busy  = 1;
        tx_never = ($urandom_range(0, 9) == 0);
        tx_left  = tx_never ? 300 : (($urandom_range(0, 4) == 0) ? FRAME : int'($urandom_range(3, 60)));
      end else if (tx_left > 0) begin
        tx_left--;
        if (tx_left == 0) begin tx_busy = 0; tx_done = !tx_never; end
      end else begin
        tx_busy = ($urandom_range(0, 9) == 0);
        tx_done = ($urandom_range(0, 39) == 0);
      end
      for (int i = 0; i < N; i++) begin
        if (req[i] && ack[i]) begin
          if ($urandom_range(0, 3) == 0) req_data[i*DW +: DW] = 8'($urandom);
          else req[i] = 1'b0;
        end else if (!req[i] && $urandom_range(0, 7) == 0) begin
          req[i] = 1'b1;
          req_data[i*DW +: DW] = 8'($urandom);
        end
      end
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
